// File: rtl/core_sequencer_if.sv
// Bus between the accumulator-core sequencer and its surroundings
// (program memory, decode, ALU, register file).
interface core_sequencer_if #(
    parameter int unsigned PC_W = 6
);
    logic            run;
    logic [7:0]      prog_data;
    logic            dest_f;
    logic            alu_zero;
    logic            bit_val;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic            w_we;
    logic            f_we;
    logic            busy;
    logic [15:0]     retired;

    modport slave (
        input  run, prog_data, dest_f, alu_zero, bit_val,
        output pc, ir, w_we, f_we, busy, retired
    );

    modport master (
        output run, prog_data, dest_f, alu_zero, bit_val,
        input  pc, ir, w_we, f_we, busy, retired
    );
endinterface

// File: rtl/core_sequencer.sv
// Fetch/execute/writeback sequencer for the 8-bit accumulator core: owns pc/ir,
// W/F write enables, GOTO and the conditional-skip instructions.
module core_sequencer #(
    parameter int unsigned PC_W     = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    core_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [7:0]      r_ir;
    logic [7:0]      w_ir_nxt;
    logic            r_w_we;
    logic            w_wwe_nxt;
    logic            r_f_we;
    logic            w_fwe_nxt;
    logic            r_skip_pend;
    logic            w_skip_nxt;
    logic [15:0]     r_retired;
    logic [15:0]     w_retired_nxt;

    // State register plus all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_pc        <= PC_W'(RESET_PC);
            r_ir        <= 8'h00;
            r_w_we      <= 1'b0;
            r_f_we      <= 1'b0;
            r_skip_pend <= 1'b0;
            r_retired   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_w_we      <= w_wwe_nxt;
            r_f_we      <= w_fwe_nxt;
            r_skip_pend <= w_skip_nxt;
            r_retired   <= w_retired_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.run) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = bus.run ? S_FETCH : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath / output next values; write enables only ever live for the WB cycle
    always_comb begin
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_wwe_nxt     = 1'b0;
        w_fwe_nxt     = 1'b0;
        w_skip_nxt    = r_skip_pend;
        w_retired_nxt = r_retired;
        unique case (r_state)
            S_FETCH: begin
                w_ir_nxt = bus.prog_data;
                w_pc_nxt = r_pc + PC_W'(1);
            end
            S_EXEC: begin
                unique case (r_ir[7:6])
                    2'b00: begin
                        // ir[5:2]=0000 with d=0 is NOP
                        if (!(r_ir[5:2] == 4'b0000 && !bus.dest_f)) begin
                            w_fwe_nxt = bus.dest_f;
                            w_wwe_nxt = ~bus.dest_f;
                        end
                        if ((r_ir[5:2] == 4'b1011 || r_ir[5:2] == 4'b1111) && bus.alu_zero)
                            w_skip_nxt = 1'b1;
                    end
                    2'b01: begin
                        unique case (r_ir[5:4])
                            2'b00, 2'b01: w_fwe_nxt = 1'b1;
                            2'b10:        if (!bus.bit_val) w_skip_nxt = 1'b1;
                            2'b11:        if (bus.bit_val)  w_skip_nxt = 1'b1;
                            default:      w_fwe_nxt = 1'b0;
                        endcase
                    end
                    2'b10:   w_pc_nxt  = r_ir[PC_W-1:0];
                    2'b11:   w_wwe_nxt = 1'b1;
                    default: w_wwe_nxt = 1'b0;
                endcase
            end
            S_WB: begin
                w_retired_nxt = r_retired + 16'd1;
                if (r_skip_pend) begin
                    w_pc_nxt   = r_pc + PC_W'(1);
                    w_skip_nxt = 1'b0;
                end
            end
            default: w_skip_nxt = r_skip_pend;
        endcase
    end

    assign bus.pc      = r_pc;
    assign bus.ir      = r_ir;
    assign bus.w_we    = r_w_we;
    assign bus.f_we    = r_f_we;
    assign bus.busy    = r_busy;
    assign bus.retired = r_retired;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: single-instruction vector table plus
// hand-written multi-instruction sequences.
module tb_core_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] prog [64];

    core_sequencer_if #(.PC_W(6)) bus ();
    core_sequencer #(.PC_W(6), .RESET_PC(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign bus.prog_data = prog[bus.pc];

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [7:0] inst;
        logic       d, az, bv;
        logic       ew, ef;
        logic [5:0] epc;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run = 1'b0;
        reset   = 1'b1;
        for (int i = 0; i < 64; i++) prog[i] = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        bus.run = 1'b0; bus.dest_f = 1'b0; bus.alu_zero = 1'b0; bus.bit_val = 1'b0;
        //          inst   d     az    bv    ew    ef    epc
        vecs[0]  = '{8'hC5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
        vecs[1]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[3]  = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
        vecs[4]  = '{8'h83, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3};
        vecs[5]  = '{8'hBF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd63};
        vecs[6]  = '{8'h2E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2};
        vecs[7]  = '{8'h2E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[8]  = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2};
        vecs[9]  = '{8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd2};
        vecs[10] = '{8'h72, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[11] = '{8'h62, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
        vecs[12] = '{8'h62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2};
        vecs[13] = '{8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[14] = '{8'h52, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[15] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1};

        // Reset state
        do_reset();
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_ir", 32'(bus.ir), 32'h00);
        check("rst_wwe", 32'(bus.w_we), 32'd0);
        check("rst_fwe", 32'(bus.f_we), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        tick();
        check("idle_hold_busy", 32'(bus.busy), 32'd0);

        // One instruction per vector, run dropped during EXEC
        for (int v = 0; v < 16; v++) begin
            do_reset();
            prog[0]      = vecs[v].inst;
            bus.dest_f   = vecs[v].d;
            bus.alu_zero = vecs[v].az;
            bus.bit_val  = vecs[v].bv;
            bus.run      = 1'b1;
            tick();
            tick();
            check($sformatf("v%0d_ir", v), 32'(bus.ir), 32'(vecs[v].inst));
            bus.run = 1'b0;
            tick();
            check($sformatf("v%0d_wwe", v), 32'(bus.w_we), 32'(vecs[v].ew));
            check($sformatf("v%0d_fwe", v), 32'(bus.f_we), 32'(vecs[v].ef));
            check($sformatf("v%0d_busy_wb", v), 32'(bus.busy), 32'd1);
            tick();
            check($sformatf("v%0d_pc", v), 32'(bus.pc), 32'(vecs[v].epc));
            check($sformatf("v%0d_retired", v), 32'(bus.retired), 32'd1);
            check($sformatf("v%0d_busy_idle", v), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_wwe_off", v), 32'(bus.w_we | bus.f_we), 32'd0);
        end

        // Continuous program MOVLW / MOVWF / NOP
        begin
            logic [7:0] p [3];
            logic       d [3];
            logic       ew [3];
            logic       ef [3];
            p  = '{8'hC5, 8'h03, 8'h00};
            d  = '{1'b0, 1'b1, 1'b0};
            ew = '{1'b1, 1'b0, 1'b0};
            ef = '{1'b0, 1'b1, 1'b0};
            do_reset();
            for (int i = 0; i < 3; i++) prog[i] = p[i];
            bus.run = 1'b1;
            tick();
            for (int i = 0; i < 3; i++) begin
                bus.dest_f = d[i];
                check($sformatf("seq%0d_fetch_pc", i), 32'(bus.pc), 32'(i));
                tick();
                check($sformatf("seq%0d_ir", i), 32'(bus.ir), 32'(p[i]));
                check($sformatf("seq%0d_exec_pc", i), 32'(bus.pc), 32'(i + 1));
                check($sformatf("seq%0d_exec_we", i), 32'(bus.w_we | bus.f_we), 32'd0);
                tick();
                check($sformatf("seq%0d_wwe", i), 32'(bus.w_we), 32'(ew[i]));
                check($sformatf("seq%0d_fwe", i), 32'(bus.f_we), 32'(ef[i]));
                tick();
                check($sformatf("seq%0d_retired", i), 32'(bus.retired), 32'(i + 1));
            end
            check("seq_final_pc", 32'(bus.pc), 32'd3);
        end

        // GOTO 63, then a taken BTFSS at 63: pc wraps on fetch and on skip
        do_reset();
        prog[0] = 8'hBF; prog[63] = 8'h72; bus.bit_val = 1'b1;
        bus.run = 1'b1;
        tick(); tick(); tick(); tick();
        check("wrap_fetch_pc", 32'(bus.pc), 32'd63);
        tick();
        check("wrap_inc_pc", 32'(bus.pc), 32'd0);
        check("wrap_ir", 32'(bus.ir), 32'h72);
        tick();
        check("wrap_btfss_we", 32'(bus.w_we | bus.f_we), 32'd0);
        tick();
        check("wrap_skip_pc", 32'(bus.pc), 32'd1);

        // DECFSZ at pc=4 skips the MOVLW at 5
        do_reset();
        prog[0] = 8'h84; prog[4] = 8'h2E; prog[5] = 8'hC1; prog[6] = 8'h00;
        bus.dest_f = 1'b1; bus.alu_zero = 1'b1; bus.bit_val = 1'b0;
        bus.run = 1'b1;
        tick(); tick(); tick(); tick();
        check("dec_fetch_pc", 32'(bus.pc), 32'd4);
        tick(); tick();
        check("dec_fwe", 32'(bus.f_we), 32'd1);
        check("dec_wwe", 32'(bus.w_we), 32'd0);
        tick();
        check("dec_next_pc", 32'(bus.pc), 32'd6);
        bus.dest_f = 1'b0;
        tick();
        check("dec_next_ir", 32'(bus.ir), 32'h00);
        tick();
        check("dec_nop_we", 32'(bus.w_we | bus.f_we), 32'd0);
        check("dec_retired", 32'(bus.retired), 32'd2);

        // Halt during EXEC, then resume from held pc
        do_reset();
        prog[0] = 8'hC5; prog[1] = 8'h42;
        bus.run = 1'b1;
        tick(); tick();
        bus.run = 1'b0;
        tick();
        check("halt_wb_busy", 32'(bus.busy), 32'd1);
        check("halt_wb_wwe", 32'(bus.w_we), 32'd1);
        tick();
        check("halt_idle_busy", 32'(bus.busy), 32'd0);
        check("halt_idle_pc", 32'(bus.pc), 32'd1);
        tick(); tick();
        check("halt_hold_pc", 32'(bus.pc), 32'd1);
        check("halt_hold_busy", 32'(bus.busy), 32'd0);
        bus.run = 1'b1;
        tick();
        check("resume_busy", 32'(bus.busy), 32'd1);
        tick();
        check("resume_ir", 32'(bus.ir), 32'h42);
        check("resume_pc", 32'(bus.pc), 32'd2);
        tick();
        check("resume_fwe", 32'(bus.f_we), 32'd1);

        // Reset asserted during EXEC of a literal op
        do_reset();
        prog[0] = 8'hC5;
        bus.run = 1'b1;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("midrst_wwe", 32'(bus.w_we), 32'd0);
        check("midrst_pc", 32'(bus.pc), 32'd0);
        check("midrst_ir", 32'(bus.ir), 32'h00);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        tick();
        check("midrst_wwe_hold", 32'(bus.w_we), 32'd0);
        reset = 1'b0;
        bus.run = 1'b0;
        tick();
        check("midrst_retired", 32'(bus.retired), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control unit for the 8-bit-instruction accumulator core. It fetches from program memory, holds the instruction register that drives the `decode` block, and sequences fetch/execute/writeback. It generates W and F register write enables, and handles the instructions `decode` does not own: the GOTO class (`ir[7:6]=10`) and the skip instructions (DECFSZ, INCFSZ, BTFSC, BTFSS).

Parameters:
PC_W, 6, program counter width; GOTO target is `ir[PC_W-1:0]`, and PC_W must be ≤ 6.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  core clock, rising edge.
reset  in  1  asynchronous, active-high reset.
run  in  1  level; high = execute, low = halt after current instruction.
prog_data  in  8  program memory read data, combinational from `pc`.
dest_f  in  1  destination from `decode` (`d`); 1 = F, 0 = W.
alu_zero  in  1  ALU result == 0, valid in EXEC.
bit_val  in  1  value of f bit `ir[3:1]`, valid in EXEC.
pc  out  PC_W  program memory address.
ir  out  8  instruction register; feeds `decode.inst_reg`.
w_we  out  1  W register write enable.
f_we  out  1  file register write enable.
busy  out  1  high in any state except IDLE.
retired  out  16  count of completed instructions, wraps.

Behaviour:
- Reset (async) values: state=IDLE, pc=RESET_PC, ir=8'h00 (NOP), w_we=0, f_we=0, skip_pend=0, retired=0.
- All outputs are registered. No combinational path exists from inputs to outputs.
- States and transitions:
  - IDLE: if `run`=1, go to FETCH; otherwise stay.
  - FETCH: `ir<=prog_data`; `pc<=pc+1` (wraps mod 2^PC_W); go to EXEC.
  - EXEC: classify `ir`; latch w_we/f_we for the next cycle; evaluate skip; for GOTO set `pc<=ir[PC_W-1:0]`; go to WB.
  - WB: w_we/f_we are high for this cycle only; `retired++`; if skip_pend, `pc<=pc+1` and clear skip_pend; next state is FETCH if `run`=1, else IDLE.
- Every instruction takes exactly 3 cycles (FETCH, EXEC, WB), including GOTO and skipped instructions.
- Write-enable classification, evaluated in EXEC. Exactly one of w_we/f_we is asserted, or neither.
  - Byte ops (`ir[7:6]=00`): `f_we=dest_f`, `w_we=~dest_f`. Exception: `ir[5:2]=0000` with dest_f=0 is NOP, so no write.
  - Bit ops `ir[5:4]=00` (BCF) or `01` (BSF): f_we=1.
  - Bit ops `ir[5:4]=10` (BTFSC) or `11` (BTFSS): no write.
  - Literal ops (`ir[7:6]=11`): w_we=1.
  - GOTO (`ir[7:6]=10`): no write.
- Skip evaluation in EXEC sets skip_pend when:
  - DECFSZ (`ir[7:6]=00`, `ir[5:2]=1011`) or INCFSZ (`1111`) and alu_zero=1; the write still occurs.
  - BTFSC and bit_val=0.
  - BTFSS and bit_val=1.
- Skip net effect: the instruction after the skipping one is never fetched; pc advances by 2 in total.
- pc wraps modulo 2^PC_W on increment and on skip increment.
- `run` deasserted during FETCH or EXEC: the current instruction still completes, including its write and skip; the block enters IDLE after WB with pc pointing at the next instruction.
- `run` reasserted in IDLE: resumes from the held pc.
- Reset mid-instruction: any pending write is discarded (w_we/f_we forced to 0 immediately) and skip_pend is cleared.
- `busy` = (state != IDLE), registered alongside the state.

Test Plan:
- Reset, then `run`=1, program {8'hC5 MOVLW, 8'h03 MOVWF-to-f, 8'h00 NOP}: pc steps 0→1→2→3 on every third cycle; w_we pulses in WB of instr 0; f_we pulses in WB of instr 1; no enable for NOP; retired=3.
- Program at 0: 8'h83 (GOTO 3): after WB pc=3, no write enables, next fetch address 3. GOTO at pc=63 with PC_W=6: plain increment wraps to 0.
- DECFSZ with dest_f=1 and alu_zero=1 at pc=4: f_we pulses, pc=6 at the next FETCH. Same instruction with alu_zero=0: pc=5.
- BTFSS (8'h72) with bit_val=1: no write, instruction skipped. BTFSC (8'h62) with bit_val=1: no skip.
- Drop `run` during EXEC: instruction completes, busy falls one cycle after WB, pc is held. Assert reset during EXEC of a literal op: w_we never pulses, pc=0, ir=00.
